boot_rom_bridge: RTL and testbench

- Request-side front end for the 4 KB secure boot ROM (1024 x 32-bit words, synchronous 1-cycle read, base 0x0000_0000).
- Accepts byte-addressed requests from the core/fetch bus over a valid/ready handshake and drives the ROM word address.
- Returns read data over a valid/ready response channel.
- Enforces immutability: writes, misaligned and out-of-range accesses return errors, and writes are logged.
- All responses have identical latency, so access legality does not leak through timing.

---
 rtl/boot_rom_bridge.sv | 105 ++++++++++
 tb/tb_boot_rom_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_bridge.sv
// Request front end for the 4 KB secure boot ROM: one outstanding access,
// fixed three-cycle turnaround, and error reporting for illegal accesses.
module boot_rom_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic                 req_we,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic [1:0]           resp_err,
    output logic [9:0]           rom_addr,
    input  logic [31:0]          rom_rdata,
    output logic                 write_violation,
    output logic [CNT_WIDTH-1:0] violation_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_WRITE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    // Range is checked before the write flag so out-of-range writes are not logged.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic we);
        if (addr[31:12] != BASE_ADDR[31:12]) return ERR_RANGE;
        else if (we)                         return ERR_WRITE;
        else if (addr[1:0] != 2'b00)         return ERR_ALIGN;
        else                                 return ERR_OK;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return v;
        else    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]           state_q, state_d;
    logic [9:0]           addr_q, addr_d;
    logic [1:0]           err_q, err_d;
    logic                 viol_q, viol_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept;
    logic [1:0]           req_class;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_class = classify(req_addr, req_we);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        viol_d  = viol_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    addr_d  = req_addr[11:2];
                    err_d   = req_class;
                    if (req_class == ERR_WRITE) begin
                        viol_d = 1'b1;
                        cnt_d  = sat_inc(cnt_q);
                    end
                end
            end
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= ERR_OK;
            viol_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            viol_q  <= viol_d;
            cnt_q   <= cnt_d;
        end
    end

    // rom_addr is held through RESP, so rom_rdata stays valid under backpressure.
    assign rom_addr        = addr_q;
    assign resp_valid      = (state_q == S_RESP);
    assign resp_err        = resp_valid ? err_q : ERR_OK;
    assign resp_rdata      = (resp_valid && err_q == ERR_OK) ? rom_rdata : 32'h0;
    assign write_violation = viol_q;
    assign violation_count = cnt_q;

endmodule

// File: tb/tb_boot_rom_bridge.sv
// Directed bench for boot_rom_bridge with a behavioural 1-cycle ROM.
module tb_boot_rom_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        write_violation;
    logic [7:0]  violation_count;

    int n_vec = 0;
    int n_err = 0;

    boot_rom_bridge #(
        .BASE_ADDR(32'h0000_0000),
        .CNT_WIDTH(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_we         (req_we),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .write_violation(write_violation),
        .violation_count(violation_count)
    );

    always #5 clk = ~clk;

    // Word 4 = DEADBEEF, every other word = 0x12345678 ^ index.
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        if (a == 10'd4) return 32'hDEAD_BEEF;
        else            return 32'h1234_5678 ^ {22'h0, a};
    endfunction

    always_ff @(posedge clk) rom_rdata <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic we,
                          input logic [1:0] eerr, input logic [31:0] edata);
        chk({tag, ".rdy"}, req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_we = we; resp_ready = 1'b1;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        chk({tag, ".romaddr"}, rom_addr, {22'h0, a[11:2]});
        chk({tag, ".vld_wait"}, resp_valid, 0);
        step();
        chk({tag, ".vld"}, resp_valid, 1);
        chk({tag, ".err"}, resp_err, eerr);
        chk({tag, ".data"}, resp_rdata, edata);
        step();
        chk({tag, ".rdy_after"}, req_ready, 1);
        chk({tag, ".vld_after"}, resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; resp_ready = 1'b0;
        #2;
        chk("rst.rdy", req_ready, 1);
        chk("rst.vld", resp_valid, 0);
        chk("rst.data", resp_rdata, 0);
        chk("rst.err", resp_err, 0);
        chk("rst.romaddr", rom_addr, 0);
        chk("rst.wv", write_violation, 0);
        chk("rst.cnt", violation_count, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        do_req("t1", 32'h0000_0010, 1'b0, 2'b00, 32'hDEAD_BEEF);

        do_req("t2w", 32'h0000_0100, 1'b1, 2'b01, 32'h0);
        chk("t2.wv", write_violation, 1);
        chk("t2.cnt", violation_count, 1);
        do_req("t2m", 32'h0000_0102, 1'b0, 2'b10, 32'h0);
        chk("t2m.cnt", violation_count, 1);

        do_req("t3a", 32'h0000_1000, 1'b0, 2'b11, 32'h0);
        do_req("t3b", 32'h8000_0000, 1'b1, 2'b11, 32'h0);
        chk("t3.cnt", violation_count, 1);

        // Backpressure on word 7 while the next request (word 8) waits.
        req_valid = 1'b1; req_addr = 32'h0000_001C; req_we = 1'b0; resp_ready = 1'b0;
        step();
        req_addr = 32'h0000_0020;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4.vld", resp_valid, 1);
            chk("t4.data", resp_rdata, 32'h1234_567F);
            chk("t4.err", resp_err, 0);
            chk("t4.rdy", req_ready, 0);
            step();
        end
        resp_ready = 1'b1;
        chk("t4.vld_last", resp_valid, 1);
        step();
        chk("t4.vld_done", resp_valid, 0);
        chk("t4.rdy_done", req_ready, 1);
        chk("t4.romaddr_hold", rom_addr, 7);
        step();
        req_valid = 1'b0;
        chk("t4.romaddr_next", rom_addr, 8);
        chk("t4.rdy_busy", req_ready, 0);
        step();
        chk("t4.vld_next", resp_valid, 1);
        chk("t4.data_next", resp_rdata, 32'h1234_5670);
        step();

        // Reset during WAIT.
        req_valid = 1'b1; req_addr = 32'h0000_001C; req_we = 1'b0;
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5a.vld", resp_valid, 0);
        chk("t5a.cnt", violation_count, 0);
        chk("t5a.wv", write_violation, 0);
        chk("t5a.rdy", req_ready, 1);
        chk("t5a.romaddr", rom_addr, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5a.nostale", resp_valid, 0);
        end

        // Reset during RESP of a write.
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_we = 1'b1; resp_ready = 1'b0;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        chk("t5b.cnt_pre", violation_count, 1);
        step();
        chk("t5b.vld_pre", resp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5b.vld", resp_valid, 0);
        chk("t5b.cnt", violation_count, 0);
        chk("t5b.wv", write_violation, 0);
        chk("t5b.err", resp_err, 0);
        step();
        rst_n = 1'b1;
        chk("t5b.rdy", req_ready, 1);
        step();
        chk("t5b.nostale", resp_valid, 0);
        do_req("t5c", 32'h0000_0010, 1'b0, 2'b00, 32'hDEAD_BEEF);

        // 300 back-to-back writes: saturation and 1-per-3-cycle throughput.
        acc = 0;
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_we = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc++;
                if (acc == 255) chk("t6.cnt_254", violation_count, 254);
            end
            step();
        end
        req_valid = 1'b0; req_we = 1'b0;
        step();
        chk("t6.accepts", acc, 300);
        chk("t6.cnt_sat", violation_count, 255);
        chk("t6.wv", write_violation, 1);
        chk("t6.rdy", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
